oc_bank_arbiter: RTL and testbench

Register-file read scheduler that feeds the operand collector units. It takes per-operand-slot read requests from up to four collectors (eight slots), arbitrates each of the four register banks round-robin, and drives the bank SRAM read ports. It returns each bank's read data tagged with the requesting slot's `ocid` on the `bk_*` bus that collectors snoop. The writeback port has priority over reads on a bank, and a write-occupied bank is signalled by `bk_n_bz`.

---
 rtl/oc_pkg.sv | 29 ++
 rtl/oc_bank_arbiter_if.sv | 48 ++++
 rtl/oc_rr_arbiter.sv | 42 ++++
 rtl/oc_bank_arbiter.sv | 121 ++++++++++++
 tb/tb_oc_bank_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oc_pkg.sv
// Operand-collector constants and register-id field helpers.
// The collector units reuse everything in this package.
package oc_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int NUM_BANKS = 4;
    localparam int OCID_W    = 3;
    localparam int REG_ID_W  = 5;
    localparam int ROW_W     = 3;
    localparam int BANK_W    = 2;
    localparam int DATA_W    = 256;
    localparam int CNT_W     = 16;

    // Per-bank result of the issue cycle, as seen one cycle later.
    typedef struct packed {
        logic              vld;
        logic              bz;
        logic [OCID_W-1:0] ocid;
    } bank_stage_t;

    function automatic logic [BANK_W-1:0] reg_bank(input logic [REG_ID_W-1:0] reg_id);
        return reg_id[REG_ID_W-1 -: BANK_W];
    endfunction

    function automatic logic [ROW_W-1:0] reg_row(input logic [REG_ID_W-1:0] reg_id);
        return reg_id[ROW_W-1:0];
    endfunction

endpackage

// File: rtl/oc_bank_arbiter_if.sv
// Read-request, writeback, SRAM and bank-broadcast signals of the bank arbiter.
// The slave modport is the arbiter; master is the collectors and SRAM around it.
interface oc_bank_arbiter_if;
    import oc_pkg::*;

    logic [NUM_SLOTS-1:0]                req_vld;
    logic [NUM_SLOTS-1:0][REG_ID_W-1:0]  req_reg_id;
    logic [NUM_SLOTS-1:0]                req_ack;

    logic                                wr_en;
    logic [REG_ID_W-1:0]                 wr_reg_id;
    logic [DATA_W-1:0]                   wr_data;

    logic [NUM_BANKS-1:0]                rf_rd_en;
    logic [NUM_BANKS-1:0][ROW_W-1:0]     rf_rd_addr;
    logic [NUM_BANKS-1:0][DATA_W-1:0]    rf_rd_data;
    logic [NUM_BANKS-1:0]                rf_wr_en;
    logic [ROW_W-1:0]                    rf_wr_addr;
    logic [DATA_W-1:0]                   rf_wr_data;

    logic [DATA_W-1:0]                   bk_0_data, bk_1_data, bk_2_data, bk_3_data;
    logic [OCID_W-1:0]                   bk_0_ocid, bk_1_ocid, bk_2_ocid, bk_3_ocid;
    logic                                bk_0_vld, bk_1_vld, bk_2_vld, bk_3_vld;
    logic                                bk_0_bz, bk_1_bz, bk_2_bz, bk_3_bz;

    logic [CNT_W-1:0]                    conflict_cnt;

    modport slave (
        input  req_vld, req_reg_id, wr_en, wr_reg_id, wr_data, rf_rd_data,
        output req_ack, rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
        output bk_0_data, bk_1_data, bk_2_data, bk_3_data,
        output bk_0_ocid, bk_1_ocid, bk_2_ocid, bk_3_ocid,
        output bk_0_vld, bk_1_vld, bk_2_vld, bk_3_vld,
        output bk_0_bz, bk_1_bz, bk_2_bz, bk_3_bz,
        output conflict_cnt
    );

    modport master (
        output req_vld, req_reg_id, wr_en, wr_reg_id, wr_data, rf_rd_data,
        input  req_ack, rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
        input  bk_0_data, bk_1_data, bk_2_data, bk_3_data,
        input  bk_0_ocid, bk_1_ocid, bk_2_ocid, bk_3_ocid,
        input  bk_0_vld, bk_1_vld, bk_2_vld, bk_3_vld,
        input  bk_0_bz, bk_1_bz, bk_2_bz, bk_3_bz,
        input  conflict_cnt
    );

endinterface

// File: rtl/oc_rr_arbiter.sv
// 8-way round-robin: combinational request-to-grant, one-hot grant,
// pointer moves to one past the winner and holds when nothing is granted.
module oc_rr_arbiter
    import oc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SLOTS-1:0] req_i,
    output logic [NUM_SLOTS-1:0] gnt_o,
    output logic                 gnt_vld_o,
    output logic [OCID_W-1:0]    gnt_idx_o
);

    logic [OCID_W-1:0] ptr_q, ptr_d;

    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        // Scan from the farthest offset down so the nearest requester wins last.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (req_i[ptr_q + OCID_W'(i)]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = ptr_q + OCID_W'(i);
            end
        end
        gnt_o = gnt_vld_o ? (NUM_SLOTS'(1) << gnt_idx_o) : '0;
        ptr_d = gnt_vld_o ? gnt_idx_o + OCID_W'(1) : ptr_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/oc_bank_arbiter.sv
// Register-file read scheduler: per-bank round-robin over eight operand slots,
// writeback has bank priority, results broadcast one cycle later tagged by ocid.
module oc_bank_arbiter
    import oc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    oc_bank_arbiter_if.slave   bus
);

    logic [BANK_W-1:0]    wr_bank;
    logic [NUM_BANKS-1:0] wr_busy;
    logic [NUM_SLOTS-1:0] cand    [NUM_BANKS];
    logic [NUM_SLOTS-1:0] arb_req [NUM_BANKS];
    logic [NUM_SLOTS-1:0] gnt     [NUM_BANKS];
    logic [OCID_W-1:0]    gnt_idx [NUM_BANKS];
    logic [NUM_BANKS-1:0] gnt_vld;
    logic                 any_wait;

    bank_stage_t [NUM_BANKS-1:0] stage_q, stage_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    assign wr_bank = reg_bank(bus.wr_reg_id);

    // A write-occupied bank sees no requests, so its pointer holds.
    always_comb begin
        wr_busy = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            wr_busy[b] = bus.wr_en && (wr_bank == BANK_W'(b));
            cand[b]    = '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                cand[b][s] = bus.req_vld[s] && (reg_bank(bus.req_reg_id[s]) == BANK_W'(b));
            end
            arb_req[b] = wr_busy[b] ? '0 : cand[b];
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        oc_rr_arbiter u_arb (
            .clk       (clk),
            .rst       (rst),
            .req_i     (arb_req[b]),
            .gnt_o     (gnt[b]),
            .gnt_vld_o (gnt_vld[b]),
            .gnt_idx_o (gnt_idx[b])
        );
    end

    always_comb begin
        bus.req_ack    = '0;
        bus.rf_rd_en   = '0;
        bus.rf_rd_addr = '0;
        bus.rf_wr_en   = '0;
        any_wait       = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bus.req_ack       = bus.req_ack | gnt[b];
            bus.rf_rd_en[b]   = gnt_vld[b];
            bus.rf_rd_addr[b] = reg_row(bus.req_reg_id[gnt_idx[b]]);
            if ((cand[b] & ~gnt[b]) != '0) begin
                any_wait = 1'b1;
            end
        end
        if (bus.wr_en) begin
            bus.rf_wr_en[wr_bank] = 1'b1;
        end
        // Strobes must not escape while reset is held, even mid-cycle.
        if (rst) begin
            bus.req_ack  = '0;
            bus.rf_rd_en = '0;
            bus.rf_wr_en = '0;
        end
    end

    assign bus.rf_wr_addr = reg_row(bus.wr_reg_id);
    assign bus.rf_wr_data = bus.wr_data;

    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            stage_d[b].vld = gnt_vld[b];
            stage_d[b].bz  = wr_busy[b];
            if (gnt_vld[b]) begin
                stage_d[b].ocid = gnt_idx[b];
            end
        end
        if (any_wait && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.bk_0_vld  = stage_q[0].vld;
    assign bus.bk_1_vld  = stage_q[1].vld;
    assign bus.bk_2_vld  = stage_q[2].vld;
    assign bus.bk_3_vld  = stage_q[3].vld;
    assign bus.bk_0_bz   = stage_q[0].bz;
    assign bus.bk_1_bz   = stage_q[1].bz;
    assign bus.bk_2_bz   = stage_q[2].bz;
    assign bus.bk_3_bz   = stage_q[3].bz;
    assign bus.bk_0_ocid = stage_q[0].ocid;
    assign bus.bk_1_ocid = stage_q[1].ocid;
    assign bus.bk_2_ocid = stage_q[2].ocid;
    assign bus.bk_3_ocid = stage_q[3].ocid;
    assign bus.bk_0_data = bus.rf_rd_data[0];
    assign bus.bk_1_data = bus.rf_rd_data[1];
    assign bus.bk_2_data = bus.rf_rd_data[2];
    assign bus.bk_3_data = bus.rf_rd_data[3];

    assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_oc_bank_arbiter.sv
// Bench for oc_bank_arbiter: directed scenarios with literal expectations, then
// random collector traffic checked every cycle against a register-file model.
module tb_oc_bank_arbiter;
    import oc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oc_bank_arbiter_if bus ();

    oc_bank_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Bank SRAMs: one-cycle read latency.
    logic [DATA_W-1:0] sram [NUM_BANKS][8];
    always @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bus.rf_rd_en[b]) bus.rf_rd_data[b] <= sram[b][bus.rf_rd_addr[b]];
            if (bus.rf_wr_en[b]) sram[b][bus.rf_wr_addr] = bus.rf_wr_data;
        end
    end

    logic [3:0]              bk_vld, bk_bz;
    logic [3:0][OCID_W-1:0]  bk_ocid;
    logic [3:0][DATA_W-1:0]  bk_data;
    assign bk_vld  = {bus.bk_3_vld, bus.bk_2_vld, bus.bk_1_vld, bus.bk_0_vld};
    assign bk_bz   = {bus.bk_3_bz, bus.bk_2_bz, bus.bk_1_bz, bus.bk_0_bz};
    assign bk_ocid = {bus.bk_3_ocid, bus.bk_2_ocid, bus.bk_1_ocid, bus.bk_0_ocid};
    assign bk_data = {bus.bk_3_data, bus.bk_2_data, bus.bk_1_data, bus.bk_0_data};

    int checks   = 0;
    int failures = 0;

    // Reference model: register contents, per-bank pointer, expected broadcast.
    logic [DATA_W-1:0] ref_mem [32];
    int                m_ptr   [NUM_BANKS];
    logic [3:0]        m_vld, m_bz;
    int                m_ocid  [NUM_BANKS];
    logic [DATA_W-1:0] m_data  [NUM_BANKS];
    int                m_cnt;
    logic [7:0]        m_ack;

    logic [NUM_SLOTS-1:0] pend, cool;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand256();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NUM_BANKS; b++) begin
            m_ptr[b]  = 0;
            m_ocid[b] = 0;
            m_data[b] = '0;
        end
        m_vld = '0;
        m_bz  = '0;
        m_cnt = 0;
        m_ack = '0;
    endtask

    task automatic clear_inputs();
        bus.req_vld    = '0;
        bus.req_reg_id = '0;
        bus.wr_en      = 1'b0;
        bus.wr_reg_id  = '0;
        bus.wr_data    = '0;
    endtask

    // One clock cycle: called at the falling edge with inputs already driven.
    task automatic cycle();
        logic [7:0] ack;
        logic [3:0] rd_en, wr_en_m;
        logic       busy, wait_any;
        int         wb, best, bestd, ncand, d, row;
        #1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            check($sformatf("bk%0d_vld", b), bk_vld[b], m_vld[b]);
            check($sformatf("bk%0d_bz", b), bk_bz[b], m_bz[b]);
            check($sformatf("bk%0d_ocid", b), bk_ocid[b], m_ocid[b]);
            if (m_vld[b]) check($sformatf("bk%0d_data", b), bk_data[b], m_data[b]);
        end
        check("conflict_cnt", bus.conflict_cnt, m_cnt);

        ack = '0; rd_en = '0; wr_en_m = '0; wait_any = 1'b0;
        wb = int'(bus.wr_reg_id) / 8;
        if (bus.wr_en) wr_en_m[wb] = 1'b1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            busy  = bus.wr_en && (wb == b);
            best  = -1;
            bestd = NUM_SLOTS;
            ncand = 0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (bus.req_vld[s] && int'(bus.req_reg_id[s]) / 8 == b) begin
                    ncand++;
                    d = (s - m_ptr[b] + NUM_SLOTS) % NUM_SLOTS;
                    if (!busy && d < bestd) begin
                        best  = s;
                        bestd = d;
                    end
                end
            end
            if (ncand > ((best >= 0) ? 1 : 0)) wait_any = 1'b1;
            m_bz[b]  = busy;
            m_vld[b] = (best >= 0);
            if (best >= 0) begin
                row       = int'(bus.req_reg_id[best]) % 8;
                ack[best] = 1'b1;
                rd_en[b]  = 1'b1;
                check($sformatf("rf_rd_addr%0d", b), bus.rf_rd_addr[b], row);
                m_ocid[b] = best;
                m_data[b] = ref_mem[b * 8 + row];
                m_ptr[b]  = (best + 1) % NUM_SLOTS;
            end
        end
        check("req_ack", bus.req_ack, ack);
        check("rf_rd_en", bus.rf_rd_en, rd_en);
        check("rf_wr_en", bus.rf_wr_en, wr_en_m);
        if (bus.wr_en) begin
            check("rf_wr_addr", bus.rf_wr_addr, int'(bus.wr_reg_id) % 8);
            check("rf_wr_data", bus.rf_wr_data, bus.wr_data);
            ref_mem[bus.wr_reg_id] = bus.wr_data;
        end
        if (wait_any && m_cnt != 16'hFFFF) m_cnt++;
        m_ack = ack;
        @(negedge clk);
    endtask

    initial begin
        logic [DATA_W-1:0] wdat;
        for (int r = 0; r < 32; r++) begin
            wdat       = rand256();
            ref_mem[r] = wdat;
            sram[r / 8][r % 8] = wdat;
        end
        model_reset();
        pend = '0;
        cool = '0;

        // Reset: strobes forced low even with traffic present.
        clear_inputs();
        bus.req_vld[0] = 1'b1;
        bus.wr_en      = 1'b1;
        bus.wr_reg_id  = 5'h08;
        #2;
        check("rst req_ack", bus.req_ack, 8'h00);
        check("rst rf_rd_en", bus.rf_rd_en, 4'h0);
        check("rst rf_wr_en", bus.rf_wr_en, 4'h0);
        check("rst bk_vld", bk_vld, 4'h0);
        check("rst conflict_cnt", bus.conflict_cnt, 16'h0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;

        // Single request: slot 3, reg 0x0A (bank 1 row 2).
        bus.req_vld[3]    = 1'b1;
        bus.req_reg_id[3] = 5'h0A;
        #1;
        check("single ack", bus.req_ack, 8'h08);
        check("single rd_en", bus.rf_rd_en, 4'b0010);
        check("single rd_addr1", bus.rf_rd_addr[1], 3'd2);
        cycle();
        clear_inputs();
        #1;
        check("single bk1_vld", bk_vld[1], 1'b1);
        check("single bk1_ocid", bk_ocid[1], 3'd3);
        check("single bk1_data", bk_data[1], ref_mem[5'h0A]);
        cycle();

        // Slots 0, 1, 5 contend for bank 2.
        bus.req_vld           = 8'b0010_0011;
        bus.req_reg_id[0]     = 5'h10;
        bus.req_reg_id[1]     = 5'h11;
        bus.req_reg_id[5]     = 5'h15;
        #1;
        check("rr first", bus.req_ack, 8'h01);
        cycle();
        bus.req_vld[0] = 1'b0;
        #1;
        check("rr second", bus.req_ack, 8'h02);
        cycle();
        bus.req_vld[1] = 1'b0;
        #1;
        check("rr third", bus.req_ack, 8'h20);
        check("rr ocid after second", bk_ocid[2], 3'd1);
        cycle();
        clear_inputs();
        #1;
        check("rr ocid after third", bk_ocid[2], 3'd5);
        check("rr conflict_cnt", bus.conflict_cnt, 16'd2);
        cycle();

        // Four banks in parallel.
        bus.req_vld       = 8'b0101_0101;
        bus.req_reg_id[0] = 5'h01;
        bus.req_reg_id[2] = 5'h09;
        bus.req_reg_id[4] = 5'h11;
        bus.req_reg_id[6] = 5'h19;
        #1;
        check("quad ack", bus.req_ack, 8'h55);
        check("quad rd_en", bus.rf_rd_en, 4'hF);
        cycle();
        clear_inputs();
        #1;
        check("quad bk_vld", bk_vld, 4'hF);
        check("quad conflict_cnt", bus.conflict_cnt, 16'd2);
        cycle();

        // Write and read of reg 0x12 in the same cycle.
        wdat              = rand256();
        bus.req_vld[2]    = 1'b1;
        bus.req_reg_id[2] = 5'h12;
        bus.wr_en         = 1'b1;
        bus.wr_reg_id     = 5'h12;
        bus.wr_data       = wdat;
        #1;
        check("raw wr_en", bus.rf_wr_en, 4'b0100);
        check("raw no ack", bus.req_ack, 8'h00);
        cycle();
        bus.wr_en = 1'b0;
        #1;
        check("raw bk2_bz", bk_bz[2], 1'b1);
        check("raw bk2_vld", bk_vld[2], 1'b0);
        check("raw deferred ack", bus.req_ack, 8'h04);
        cycle();
        clear_inputs();
        #1;
        check("raw bk2_vld late", bk_vld[2], 1'b1);
        check("raw bk2_ocid", bk_ocid[2], 3'd2);
        check("raw bk2_data", bk_data[2], wdat);
        check("raw conflict_cnt", bus.conflict_cnt, 16'd3);
        cycle();

        // Random collector traffic.
        for (int n = 0; n < 2000; n++) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (!pend[s] && !cool[s] && $urandom_range(3) == 0) begin
                    pend[s]           = 1'b1;
                    bus.req_reg_id[s] = 5'($urandom_range(31));
                end
            end
            bus.req_vld   = pend;
            bus.wr_en     = ($urandom_range(3) == 0);
            bus.wr_reg_id = 5'($urandom_range(31));
            bus.wr_data   = rand256();
            cycle();
            for (int s = 0; s < NUM_SLOTS; s++) begin
                cool[s] = m_ack[s];
                if (m_ack[s]) pend[s] = 1'b0;
            end
        end
        clear_inputs();
        pend = '0;
        repeat (3) cycle();

        // Reset mid-operation, then grant order proves the pointer cleared.
        bus.req_vld       = 8'b0010_0010;
        bus.req_reg_id[1] = 5'h03;
        bus.req_reg_id[5] = 5'h1D;
        #1;
        check("pre-rst ack", bus.req_ack, 8'h22);
        cycle();
        clear_inputs();
        #1;
        check("pre-rst bk0_vld", bk_vld[0], 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("async rst bk_vld", bk_vld, 4'h0);
        check("async rst bk_bz", bk_bz, 4'h0);
        check("async rst bk_ocid", bk_ocid, 12'h0);
        check("async rst conflict_cnt", bus.conflict_cnt, 16'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.req_vld       = 8'b0100_0100;
        bus.req_reg_id[2] = 5'h18;
        bus.req_reg_id[6] = 5'h19;
        #1;
        check("post-rst first", bus.req_ack, 8'h04);
        cycle();
        bus.req_vld[2] = 1'b0;
        #1;
        check("post-rst second", bus.req_ack, 8'h40);
        cycle();
        clear_inputs();
        cycle();

        // Saturation under a permanent bank-0 conflict.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        bus.req_vld       = 8'b0000_0011;
        bus.req_reg_id[0] = 5'h00;
        bus.req_reg_id[1] = 5'h01;
        repeat (100) @(negedge clk);
        #1;
        check("sat 100", bus.conflict_cnt, 16'd100);
        repeat (65434) @(negedge clk);
        #1;
        check("sat FFFE", bus.conflict_cnt, 16'hFFFE);
        @(negedge clk);
        #1;
        check("sat FFFF", bus.conflict_cnt, 16'hFFFF);
        repeat (100) @(negedge clk);
        #1;
        check("sat hold", bus.conflict_cnt, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
